// File: rtl/tx_block.sv
// tx_block: UART transmitter.
//   Sends one byte per frame on serial_out. A frame is a start bit (0), then
//   5-8 data bits LSB first, an optional parity bit, and one stop bit (1).
//   Each bit lasts P = max(bit_period, MIN_PERIOD) clocks.
//   A one-entry holding register sits in front of the shift register. A new
//   byte can therefore be queued while a frame is on the line, and the next
//   frame starts straight after the stop bit with no idle clock.
//
// Optional feature macro: TX_PARITY_EN
//   When defined, the port parity_odd and a PARITY state after DATA are added.
//   The parity bit is the XOR of the N data bits, inverted when parity_odd is 1.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   tx_data    in   8   byte to send; MSBs beyond data_size are ignored
//   tx_load    in   1   write strobe, accepted only while tx_ready=1
//   data_size  in   4   data bits per frame, 5..8; any other value means 8
//   bit_period in  14   clocks per serial bit
//   parity_odd in   1   odd parity select (TX_PARITY_EN builds only)
//   serial_out out  1   line output, idles high
//   tx_ready   out  1   holding register empty
//   tx_busy    out  1   frame in progress
//   tx_done    out  1   one-cycle pulse during the last clock of the stop bit
//
// Handshake: a byte is transferred on a rising edge where tx_load=1 and
// tx_ready=1. tx_ready then drops until the holding register has been moved
// into the shift register at the start of a frame. A tx_load while tx_ready=0
// is ignored.
module tx_block #(
  parameter int MIN_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic        tx_load,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
`ifdef TX_PARITY_EN
  input  logic        parity_odd,
`endif
  output logic        serial_out,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [7:0]  holding;
  logic [7:0]  shift, shift_d;
  logic [13:0] cnt, cnt_d;
  logic [13:0] reload;          // P-1 for the frame in progress
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [2:0]  last_bit;        // N-1 for the frame in progress

  logic        bit_end;
  logic        frame_start;
  logic        accept;
  logic        ready_d;
  logic        line_d;
  logic        done_d;
  logic [13:0] eff_period;
  logic [3:0]  n_eff;
  logic [2:0]  last_new;

`ifdef TX_PARITY_EN
  logic        par_bit;
  logic        par_new;
  logic [7:0]  par_mask;
`endif

  assign bit_end     = (cnt == 14'd0);
  assign accept      = tx_load & tx_ready;
  // Entering START from IDLE or STOP loads a new frame.
  assign frame_start = (state_d == START) && (state != START);

  // Frame settings sampled only at frame start.
  assign eff_period = (bit_period < 14'(MIN_PERIOD)) ? 14'(MIN_PERIOD) : bit_period;
  assign n_eff      = ((data_size >= 4'd5) && (data_size <= 4'd8)) ? data_size : 4'd8;
  assign last_new   = 3'(n_eff - 4'd1);

`ifdef TX_PARITY_EN
  assign par_mask = 8'hFF >> (4'd8 - n_eff);
  assign par_new  = (^(holding & par_mask)) ^ parity_odd;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      holding    <= '0;
      shift      <= '0;
      cnt        <= '0;
      reload     <= '0;
      bit_cnt    <= '0;
      last_bit   <= '0;
      serial_out <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      serial_out <= line_d;
      tx_ready   <= ready_d;
      tx_busy    <= (state_d != IDLE);
      tx_done    <= done_d;
      if (accept) holding <= tx_data;
      if (frame_start) begin
        reload   <= eff_period - 14'd1;
        last_bit <= last_new;
`ifdef TX_PARITY_EN
        par_bit  <= par_new;
`endif
      end
    end
  end

  // Next-state logic. The holding register is full whenever tx_ready=0.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!tx_ready) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_cnt == last_bit)) begin
`ifdef TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) state_d = tx_ready ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. serial_out is registered from line_d,
  // so the line changes on the same edge as the state.
  always_comb begin
    shift_d   = shift;
    cnt_d     = cnt;
    bit_cnt_d = '0;
    ready_d   = tx_ready;
    line_d    = 1'b1;
    // The stop bit's last clock is the cycle where cnt is 0; the reload value
    // is at least 3, so cnt==1 is seen exactly once per stop bit.
    done_d    = (state == STOP) && (cnt == 14'd1);

    if (frame_start) begin
      shift_d = holding;
    end else if ((state == DATA) && bit_end) begin
      shift_d = {1'b0, shift[7:1]};
    end

    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (frame_start) begin
      cnt_d = eff_period - 14'd1;
    end else if (bit_end) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt - 14'd1;
    end

    if (state == DATA) begin
      bit_cnt_d = bit_end ? (bit_cnt + 3'd1) : bit_cnt;
    end

    if (accept) begin
      ready_d = 1'b0;
    end else if (frame_start) begin
      ready_d = 1'b1;
    end

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY:  line_d = par_bit;
`endif
      default: line_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_tx_block.sv
// tb_tx_block: directed test of the UART transmitter tx_block.
// Each frame's expected line bits come from the byte under test and are queued
// in exp_q. Every clock of every bit is then compared against the line, along
// with tx_done and tx_busy.
module tb_tx_block;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
`ifdef TX_PARITY_EN
  logic        parity_odd;
`endif
  logic        serial_out;
  logic        tx_ready;
  logic        tx_busy;
  logic        tx_done;

  int checks;
  int errors;
  logic [0:0] exp_q[$];

  tx_block #(.MIN_PERIOD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .data_size  (data_size),
    .bit_period (bit_period),
`ifdef TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .serial_out (serial_out),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks. Inputs change and outputs are sampled 1 time unit after
  // each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_line"},  serial_out, 1);
    check_eq({tag, "_ready"}, tx_ready,   1);
    check_eq({tag, "_busy"},  tx_busy,    0);
    check_eq({tag, "_done"},  tx_done,    0);
  endtask

  // Called right after the START edge. Checks every clock of the frame and
  // returns just after the edge that ends the stop bit.
  task automatic run_frame(input logic [7:0] d, input int n, input int p,
                           input logic has_par, input logic par);
    int nb;
    logic e;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
    if (has_par) exp_q.push_back(par);
    exp_q.push_back(1'b1);
    nb = exp_q.size();
    for (int b = 0; b < nb; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < p; c++) begin
        check_eq("line", serial_out, e);
        check_eq("done", tx_done, ((b == nb - 1) && (c == p - 1)) ? 1 : 0);
        check_eq("busy", tx_busy, 1);
        tick();
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_load    = 1'b0;
    data_size  = 4'd8;
    bit_period = 14'd10;
`ifdef TX_PARITY_EN
    parity_odd = 1'b0;
`endif
    checks = 0;
    errors = 0;

    // 1) reset, then idle
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq("idle_line", serial_out, 1);
      tick();
    end
    check_idle("idle");

    // 2) 0xA5, 8 bits, P=10
    load_byte(8'hA5);
    check_eq("t2_ready_after_load", tx_ready, 0);
    check_eq("t2_busy_after_load", tx_busy, 0);
    check_eq("t2_line_after_load", serial_out, 1);
    tick();
    check_eq("t2_ready_at_start", tx_ready, 1);
    run_frame(8'hA5, 8, 10, 1'b0, 1'b0);
    check_idle("t2_end");

    // 3) 5-bit frame of 0xFF; settings changed mid-frame are ignored
    data_size = 4'd5;
    load_byte(8'hFF);
    tick();
    data_size  = 4'd8;
    bit_period = 14'd20;
    run_frame(8'hFF, 5, 10, 1'b0, 1'b0);
    check_idle("t3_end");

    // 4) back-to-back frames at P=4; a load while tx_ready=0 is dropped
    bit_period = 14'd4;
    load_byte(8'h3C);
    tick();
    fork
      run_frame(8'h3C, 8, 4, 1'b0, 1'b0);
      begin
        check_eq("t4_ready_at_start", tx_ready, 1);
        repeat (6) tick();
        load_byte(8'hC3);
        check_eq("t4_ready_after_second", tx_ready, 0);
        repeat (3) tick();
        load_byte(8'h55);
        check_eq("t4_ready_after_third", tx_ready, 0);
      end
    join
    check_eq("t4_gap_busy", tx_busy, 1);
    check_eq("t4_gap_ready", tx_ready, 1);
    run_frame(8'hC3, 8, 4, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check_eq("t4_no_third_line", serial_out, 1);
      check_eq("t4_no_third_busy", tx_busy, 0);
      tick();
    end

    // 5) bit_period=1 uses 4 clocks per bit; reset in DATA aborts the frame
    bit_period = 14'd1;
    load_byte(8'h01);
    tick();
    for (int c = 0; c < 9; c++) begin
      check_eq("t5_line", serial_out, (c >= 4 && c < 8) ? 1 : 0);
      check_eq("t5_busy", tx_busy, 1);
      tick();
    end
    rst = 1'b1;
    tick();
    check_idle("t5_after_rst");
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check_eq("t5_no_done", tx_done, 0);
      check_eq("t5_line_idle", serial_out, 1);
      tick();
    end

`ifdef TX_PARITY_EN
    // 6) parity of 0x07 (three ones): even gives 1, odd gives 0
    bit_period = 14'd10;
    data_size  = 4'd8;
    parity_odd = 1'b0;
    load_byte(8'h07);
    tick();
    run_frame(8'h07, 8, 10, 1'b1, 1'b1);
    check_idle("t6_even_end");
    parity_odd = 1'b1;
    load_byte(8'h07);
    tick();
    run_frame(8'h07, 8, 10, 1'b1, 1'b0);
    check_idle("t6_odd_end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
